fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 94 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch unit side: issues requests, consumes responses
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests, returns responses
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, delivers
// fetched words to IF/ID, handles stall backpressure and branch redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  output logic                flush,
  output logic                valid_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         instruction_out
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;

  logic [31:0] pc_inc_d;
  logic [31:0] redir_pc_d;
  logic        req_fire;
  logic        consume;

  assign pc_inc_d   = pc_q + 32'd4;
  assign redir_pc_d = redirect_pc & 32'hFFFF_FFFC;

  // A new request is held off while the current output is stuck behind a stall
  assign imem.imem_req_valid = !rst && (state_q == ST_REQ) && !(valid_q && stall);
  assign imem.imem_req_addr  = pc_q;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
  assign consume             = valid_q && !stall;

  assign flush           = redirect_valid && !rst;
  assign valid_out       = valid_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;

  // Fetch FSM with registered delivery outputs; redirect outranks stall and responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= '0;
    end else if (redirect_valid) begin
      pc_q    <= redir_pc_d;
      valid_q <= 1'b0;
      instr_q <= '0;
      // An in-flight request's response must be swallowed in DROP
      case (state_q)
        ST_REQ:  state_q <= req_fire ? ST_DROP : ST_REQ;
        ST_WAIT: state_q <= imem.imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_q <= imem.imem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_q <= ST_REQ;
      endcase
    end else begin
      if (consume) begin
        valid_q <= 1'b0;
        instr_q <= '0;
      end
      case (state_q)
        ST_REQ: begin
          if (req_fire) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_rsp_valid) begin
            valid_q  <= 1'b1;
            pc_out_q <= pc_q;
            instr_q  <= imem.imem_rsp_data;
            pc_q     <= pc_inc_d;
            state_q  <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem.imem_rsp_valid) state_q <= ST_REQ;
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

endmodule
